dff_bank_write_arbiter: RTL and testbench
=========================================

# dff_bank_write_arbiter

Round-robin write arbiter and sequencer for a shared WIDTH-bit register bank built from negative-edge-triggered D flip-flops with asynchronous active-high reset. The arbiter runs on the posedge of the same clk and shares the bank between NREQ requesters. It presents the winner's data half a cycle before the bank's capture edge, then reads back the bank output. It retries on mismatch and acknowledges the requester.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register bank width
- MAX_RETRY, 2, re-write attempts after a readback mismatch before flagging an error

- clk  input  1  clock; arbiter on posedge, bank captures on negedge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  write request per requester, level, held until ack
- wdata  input  NREQ*WIDTH  write data; requester i uses slice [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- ack  output  NREQ  one-cycle completion pulse to the granted requester
- reg_d  output  WIDTH  data to bank D inputs
- reg_we  output  1  bank capture enable, valid across the following negedge
- reg_q  input  WIDTH  bank Q readback
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky; set when retries are exhausted; cleared only by rst

## Operation
- States: IDLE, GRANT, CHECK, ACK.
- IDLE:
  - If any req bit is set, select the winner by round-robin starting at pointer ptr.
  - Register gnt = onehot(winner), reg_d = winner slice, reg_we = 1, retry = 0. Go to GRANT.
- GRANT:
  - The bank captures reg_d at the negedge inside this cycle.
  - Next state is CHECK; reg_we <= 0.
- CHECK:
  - reg_q is stable. Compare it with reg_d.
  - Match: go to ACK.
  - Mismatch with retry < MAX_RETRY: retry++, reg_we <= 1, go to GRANT.
  - Mismatch with retry == MAX_RETRY: set err, go to ACK.
- ACK:
  - ack[winner] = 1 for exactly one cycle.
  - gnt <= 0, ptr <= (winner+1) mod NREQ. Go to IDLE.
- gnt stays constant from GRANT through ACK. reg_d holds its value until the next grant.
- A req deasserted mid-transaction does not abort it. The write and the ack still complete.
- A requester still asserting req in the IDLE cycle after its ack is treated as a new request, subject to round-robin.
- Data arithmetic: none. The comparison is a full WIDTH-bit equality. The retry counter is ceil(log2(MAX_RETRY+1)) bits wide.

## Timing
- Reset values: gnt=0, ack=0, reg_d=0, reg_we=0, busy=0, err=0, ptr=0, state=IDLE, retry=0.
- rst mid-transaction returns to IDLE at once. No ack is issued. The bank is reset by the same rst.
- Latency without retry, for req sampled at posedge N:
  - gnt, reg_we and busy high in cycle N+1
  - capture at the negedge inside N+1
  - CHECK in N+2
  - ack in N+3
  - IDLE in N+4, with the next grant earliest at N+5's posedge decision
- Each retry adds 2 cycles.
- Back-to-back: at most one grant per 4 cycles. All requests are serviced within NREQ transactions (no starvation).
- Simultaneous requests: the lowest index at or after ptr wins, with wrap-around from NREQ-1 to 0.

## Configuration
- DFF_ARB_FIXED_PRIORITY_EN:
  - Defined: fixed priority, where the lowest requesting index always wins. ptr is not implemented and gnt ignores ptr.
  - Undefined (default): round-robin as above.

## Test plan
- Single requester: req=4'b0010, wdata slice1=8'hA5, reg_q follows bank.
  - Required: gnt=0010 and reg_we=1 at N+1; reg_q=A5 after the negedge; ack=0010 at N+3; err=0.
- All four request simultaneously after reset, each holding until ack.
  - Required: grant order 0,1,2,3 and then 0 again, with ack spacing of 4 cycles.
- Bank readback forced stuck at 8'h00 while writing 8'h3C, MAX_RETRY=2.
  - Required: GRANT/CHECK repeated 3 times, err=1, ack issued at N+7, err stays 1 until rst.
- rst asserted during GRANT.
  - Required: gnt, reg_we, busy and ack all 0 immediately; ptr=0; no ack pulse; next req is serviced normally.
- req dropped in the CHECK cycle.
  - Required: ack is still pulsed at N+3 and the bank holds the written value.
- DFF_ARB_FIXED_PRIORITY_EN defined, req=4'b1010 held continuously.
  - Required: requester 1 is granted every transaction and requester 3 never is.

Source files
------------

// File: rtl/dff_bank_write_arbiter_if.sv
// Bus bundle between the bank write arbiter and its requesters plus the
// negedge D-flop register bank it writes and reads back.
interface dff_bank_write_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      reg_d;
  logic                  reg_we;
  logic [WIDTH-1:0]      reg_q;
  logic                  busy;
  logic                  err;

  modport slave (
    input  req, wdata, reg_q,
    output gnt, ack, reg_d, reg_we, busy, err
  );

  modport master (
    output req, wdata, reg_q,
    input  gnt, ack, reg_d, reg_we, busy, err
  );
endinterface

// File: rtl/dff_bank_write_arbiter.sv
// Round-robin write arbiter/sequencer for a negedge-captured register bank with readback retry.
// Define DFF_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority (no rotating pointer).
module dff_bank_write_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  dff_bank_write_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, CHECK, ACK} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  reg_d_q, reg_d_d;
  logic              reg_we_q, reg_we_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [IW-1:0]     pick_c;
  logic              found_c;
  logic [WIDTH-1:0]  wslice_c [NREQ];
`ifndef DFF_ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [IW-1:0]     idx_c;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign wslice_c[g] = bus.wdata[g*WIDTH +: WIDTH];
  end

  // Winner selection: first requester at or after the pointer (or from index 0)
  always_comb begin
    pick_c  = '0;
    found_c = 1'b0;
`ifdef DFF_ARB_FIXED_PRIORITY_EN
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found_c && bus.req[IW'(i)]) begin
        pick_c  = IW'(i);
        found_c = 1'b1;
      end
    end
`else
    idx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = IW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && bus.req[idx_c]) begin
        pick_c  = idx_c;
        found_c = 1'b1;
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    reg_d_d  = reg_d_q;
    reg_we_d = reg_we_q;
    err_d    = err_q;
    retry_d  = retry_q;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
    ptr_d    = ptr_q;
    win_d    = win_q;
`endif
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d  = GRANT;
          gnt_d    = NREQ'(1) << pick_c;
          reg_d_d  = wslice_c[pick_c];
          reg_we_d = 1'b1;
          retry_d  = '0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
          win_d    = pick_c;
`endif
        end
      end
      GRANT: begin
        state_d  = CHECK;
        reg_we_d = 1'b0;
      end
      CHECK: begin
        if (bus.reg_q == reg_d_q) begin
          state_d = ACK;
          ack_d   = gnt_q;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          state_d  = GRANT;
          retry_d  = retry_q + RW'(1);
          reg_we_d = 1'b1;
        end else begin
          state_d = ACK;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = '0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
        ptr_d   = IW'((32'(win_q) + 32'd1) % NREQ);
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      reg_d_q  <= '0;
      reg_we_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      retry_q  <= '0;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
      ptr_q    <= '0;
      win_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      reg_d_q  <= reg_d_d;
      reg_we_q <= reg_we_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      retry_q  <= retry_d;
`ifndef DFF_ARB_FIXED_PRIORITY_EN
      ptr_q    <= ptr_d;
      win_q    <= win_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.reg_we = reg_we_q;
  assign bus.busy   = busy_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_dff_bank_write_arbiter.sv
// Directed bench for dff_bank_write_arbiter with a negedge D-flop bank model
// and a stuck-at-zero readback override.
module tb_dff_bank_write_arbiter;
  localparam int unsigned NREQ      = 4;
  localparam int unsigned WIDTH     = 8;
  localparam int unsigned MAX_RETRY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stuck = 1'b0;
  logic [WIDTH-1:0] bank_q;
  int n_chk = 0;
  int n_fail = 0;

  dff_bank_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_bank_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk or posedge rst) begin
    if (rst)             bank_q <= '0;
    else if (bus.reg_we) bank_q <= bus.reg_d;
  end
  assign bus.reg_q = stuck ? '0 : bank_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_gnt",    32'(bus.gnt),    32'h0);
    chk("rst_ack",    32'(bus.ack),    32'h0);
    chk("rst_reg_d",  32'(bus.reg_d),  32'h0);
    chk("rst_reg_we", 32'(bus.reg_we), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_err",    32'(bus.err),    32'h0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    step();
    do_reset();

`ifdef DFF_ARB_FIXED_PRIORITY_EN
    // Requester 1 always beats 3 under fixed priority
    bus.wdata = 32'hBB00AA00;
    bus.req   = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("fp_gnt",   32'(bus.gnt),   32'h2);
      chk("fp_reg_d", 32'(bus.reg_d), 32'hAA);
      step();
      step();
      chk("fp_ack",   32'(bus.ack),   32'h2);
      step();
      chk("fp_idle",  32'(bus.busy),  32'h0);
    end
    bus.req = '0;
`else
    // Single requester 1
    bus.wdata = 32'h0000A500;
    bus.req   = 4'b0010;
    step();
    chk("s_gnt",    32'(bus.gnt),    32'h2);
    chk("s_we",     32'(bus.reg_we), 32'h1);
    chk("s_busy",   32'(bus.busy),   32'h1);
    chk("s_reg_d",  32'(bus.reg_d),  32'hA5);
    step();
    chk("s_reg_q",  32'(bus.reg_q),  32'hA5);
    chk("s_we_off", 32'(bus.reg_we), 32'h0);
    chk("s_no_ack", 32'(bus.ack),    32'h0);
    step();
    chk("s_ack",    32'(bus.ack),    32'h2);
    chk("s_err",    32'(bus.err),    32'h0);
    bus.req = '0;
    step();
    chk("s_ack_end", 32'(bus.ack),   32'h0);
    chk("s_gnt_end", 32'(bus.gnt),   32'h0);
    chk("s_idle",    32'(bus.busy),  32'h0);

    // All four requesting continuously: order 0,1,2,3,0 every 4 cycles
    do_reset();
    bus.wdata = 32'h44332211;
    bus.req   = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt",   32'(bus.gnt),   32'(1 << (k % 4)));
      chk("rr_reg_d", 32'(bus.reg_d), 32'h11 * 32'((k % 4) + 1));
      step();
      step();
      chk("rr_ack",   32'(bus.ack),   32'(1 << (k % 4)));
      step();
      chk("rr_idle",  32'(bus.busy),  32'h0);
    end
    bus.req = '0;

    // Readback stuck at zero: three write attempts, then err and ack at N+7
    stuck     = 1'b1;
    bus.wdata = 32'h0000003C;
    bus.req   = 4'b0001;
    step();
    chk("st_gnt",   32'(bus.gnt),    32'h1);
    chk("st_we1",   32'(bus.reg_we), 32'h1);
    step();
    chk("st_chk1",  32'(bus.reg_we), 32'h0);
    step();
    chk("st_we2",   32'(bus.reg_we), 32'h1);
    chk("st_gnt2",  32'(bus.gnt),    32'h1);
    step();
    chk("st_noack", 32'(bus.ack),    32'h0);
    step();
    chk("st_we3",   32'(bus.reg_we), 32'h1);
    step();
    chk("st_err0",  32'(bus.err),    32'h0);
    chk("st_ack0",  32'(bus.ack),    32'h0);
    step();
    chk("st_ack",   32'(bus.ack),    32'h1);
    chk("st_err",   32'(bus.err),    32'h1);
    bus.req = '0;
    stuck   = 1'b0;
    step();
    chk("st_ack_end", 32'(bus.ack),  32'h0);
    chk("st_err_hold", 32'(bus.err), 32'h1);

    // Clean write after the error leaves err sticky
    bus.wdata = 32'h005A0000;
    bus.req   = 4'b0100;
    step();
    chk("pe_gnt",   32'(bus.gnt),  32'h4);
    step();
    step();
    chk("pe_ack",   32'(bus.ack),  32'h4);
    chk("pe_err",   32'(bus.err),  32'h1);
    bus.req = '0;
    step();

    // rst during GRANT: immediate clear, no ack, pointer back to 0
    bus.wdata = 32'hC30000E1;
    bus.req   = 4'b1000;
    step();
    chk("ra_gnt",   32'(bus.gnt),    32'h8);
    bus.req = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("ra_gnt0",  32'(bus.gnt),    32'h0);
    chk("ra_we0",   32'(bus.reg_we), 32'h0);
    chk("ra_busy0", 32'(bus.busy),   32'h0);
    chk("ra_ack0",  32'(bus.ack),    32'h0);
    chk("ra_err0",  32'(bus.err),    32'h0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ra_no_ack", 32'(bus.ack), 32'h0);
    end
    bus.req = 4'b1001;
    step();
    chk("ra_gnt_ptr0", 32'(bus.gnt),   32'h1);
    chk("ra_reg_d",    32'(bus.reg_d), 32'hE1);
    step();
    step();
    chk("ra_ack",      32'(bus.ack),   32'h1);
    bus.req = '0;
    step();

    // req dropped in CHECK still completes
    bus.wdata = 32'h00770000;
    bus.req   = 4'b0100;
    step();
    chk("dr_gnt",   32'(bus.gnt),   32'h4);
    step();
    bus.req = '0;
    step();
    chk("dr_ack",   32'(bus.ack),   32'h4);
    step();
    chk("dr_bank",  32'(bus.reg_q), 32'h77);
    chk("dr_gnt0",  32'(bus.gnt),   32'h0);
    step();
    chk("dr_idle",  32'(bus.busy),  32'h0);
    chk("dr_noack", 32'(bus.ack),   32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
